// File: rtl/mem_store_unit_pkg.sv
// Shared encodings and payload types for the MEM-stage store path.
package mem_store_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [BE_W-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } sb_data_t;

endpackage

// File: rtl/mem_store_unit_store_align.sv
// Combinational lane alignment of store data and byte enables, with legality check.
module store_align
    import mem_store_unit_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] wdata_c_o,
    output logic [BE_W-1:0]   be_c_o,
    output logic              misalign_c_o
);

    always_comb begin
        wdata_c_o    = data_i;
        be_c_o       = '0;
        misalign_c_o = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                wdata_c_o = {4{data_i[7:0]}};
                be_c_o    = BE_W'(BE_BYTE0 << addr_lo_i);
            end
            SZ_HALF: begin
                wdata_c_o    = {2{data_i[15:0]}};
                be_c_o       = addr_lo_i[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign_c_o = addr_lo_i[0];
            end
            SZ_WORD: begin
                be_c_o       = BE_WORD;
                misalign_c_o = |addr_lo_i;
            end
            default: misalign_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store buffer: aligns stores, queues them, drains to data memory over valid/ack.
// Optional store-to-load hazard detection is enabled by defining STORE_FWD_EN.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_inSTVALID,
    input  logic [AW-1:0]     MEM_inADDR,
    input  logic [DATA_W-1:0] MEM_inSTDATA,
    input  logic [1:0]        MEM_inSIZE,
    output logic              MEM_outSTREADY,
    output logic              MEM_outMISALIGN,
    output logic              MEM_outSBEMPTY,
    output logic              DM_outWEN,
    output logic [AW-1:0]     DM_outADDR,
    output logic [DATA_W-1:0] DM_outWDATA,
    output logic [BE_W-1:0]   DM_outBE,
`ifdef STORE_FWD_EN
    input  logic              MEM_inLDVALID,
    input  logic [AW-1:0]     MEM_inLDADDR,
    output logic              MEM_outLDSTALL,
`endif
    input  logic              DM_inACK
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [AW-1:0]     addr_q [DEPTH];
    sb_data_t          data_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              stready_q, sbempty_q, misalign_q;
    sb_state_e         state_q, state_d;

    logic [DATA_W-1:0] al_wdata;
    logic [BE_W-1:0]   al_be;
    logic              al_misalign;
    logic              accept, push, pop, wen;

    store_align u_align (
        .addr_lo_i    (MEM_inADDR[1:0]),
        .size_i       (MEM_inSIZE),
        .data_i       (MEM_inSTDATA),
        .wdata_c_o    (al_wdata),
        .be_c_o       (al_be),
        .misalign_c_o (al_misalign)
    );

    assign wen    = (state_q == SB_DRAIN);
    assign accept = MEM_inSTVALID && stready_q;
    assign push   = accept && !al_misalign;
    assign pop    = wen && DM_inACK;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: DRAIN whenever at least one entry is buffered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE:  if (push) state_d = SB_DRAIN;
            SB_DRAIN: if (pop && !push && (count_q == CW'(1))) state_d = SB_IDLE;
            default:  state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SB_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            stready_q  <= 1'b1;
            sbempty_q  <= 1'b1;
            misalign_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            stready_q  <= (count_d < CW'(DEPTH));
            sbempty_q  <= (count_d == CW'(0));
            misalign_q <= accept && al_misalign;
            if (push) begin
                addr_q[wr_ptr_q] <= {MEM_inADDR[AW-1:2], 2'b00};
                data_q[wr_ptr_q] <= '{wdata: al_wdata, be: al_be};
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign MEM_outSTREADY  = stready_q;
    assign MEM_outSBEMPTY  = sbempty_q;
    assign MEM_outMISALIGN = misalign_q;
    assign DM_outWEN       = wen;
    assign DM_outADDR      = addr_q[rd_ptr_q];
    assign DM_outWDATA     = data_q[rd_ptr_q].wdata;
    assign DM_outBE        = data_q[rd_ptr_q].be;

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (pop)  valid_q[rd_ptr_q] <= 1'b0;
            if (push) valid_q[wr_ptr_q] <= 1'b1;
        end
    end

    // Word-granular match of an incoming load against any buffered store.
    always_comb begin
        MEM_outLDSTALL = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && (addr_q[i][AW-1:2] == MEM_inLDADDR[AW-1:2]))
                MEM_outLDSTALL = MEM_inLDVALID;
        end
    end
`endif

endmodule
